miner_io_ctrl: RTL and testbench
================================

# miner_io_ctrl

Host-side sequencer for the miner core. Parses the incoming byte stream from the host link, feeds the 80-byte job (76-byte blob plus 4-byte target) into the job shift register, and starts the hash core. When the core reports a found nonce, it loads the nonce shift register and streams a framed 8-byte result back to the host. It sits between the UART byte FIFOs and the job/nonce shift registers plus the hash core.

## Interface
- JOB_BYTES, 80, job payload length in bytes (640 bits)
- NONCE_BYTES, 8, result nonce length in bytes
- RX_TIMEOUT, 1_000_000, idle cycles allowed between job bytes before the frame is dropped
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- job_byte  out  8  byte presented to the job shift register
- job_shift  out  1  one-cycle strobe; job shift register captures job_byte
- miner_start  out  1  one-cycle pulse; job register is complete
- miner_abort  out  1  one-cycle pulse; stop current search
- miner_found  in  1  one-cycle pulse; nonce valid on found_nonce
- found_nonce  in  64  winning nonce
- nonce_load  out  1  one-cycle load strobe to the nonce shift register
- nonce_shift  out  1  shift enable to the nonce shift register
- nonce_byte  in  8  nonce shift register output byte
- tx_data  out  8  byte to host
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  host link accepts the byte
- rx_err_cnt  out  8  saturating count of dropped job frames

## Operation
- Frame from host: header 0x4A ('J') followed by JOB_BYTES payload bytes, MSB first. Frame to host: header 0x4E ('N') followed by NONCE_BYTES bytes, MSB first.
- IDLE: rx_ready=1. A 0x4A byte moves the FSM to RECV and clears the byte counter. Any other byte is discarded.
- RECV: rx_ready=1. Each accepted byte drives job_byte=rx_data and job_shift=1 in the same cycle, then increments the counter. After the JOB_BYTES-th byte the FSM goes to START.
  - If no byte is accepted for RX_TIMEOUT consecutive cycles, the FSM returns to IDLE and increments rx_err_cnt, saturating at 255.
- START: miner_start=1 for one cycle, then RUN.
- RUN: rx_ready=1.
  - An accepted 0x4A asserts miner_abort for one cycle and enters RECV, which loads a new job.
  - Other bytes are discarded.
  - miner_found captures found_nonce and goes to LOAD.
  - If miner_found and an accepted 0x4A occur in the same cycle, the found result is taken and the rx byte is dropped.
- LOAD: nonce_load=1 for one cycle, then HDR.
- HDR: tx_data=0x4E, tx_valid=1. On handshake, go to SHIFT.
- SHIFT: nonce_shift=1 for one cycle, then SEND.
- SEND: tx_data=nonce_byte, tx_valid=1. On handshake:
  - increment the byte counter;
  - if NONCE_BYTES bytes have been sent, go to RUN, because the miner continues searching;
  - otherwise go back to SHIFT.
- rx_ready=0 in START, LOAD, HDR, SHIFT and SEND. Further miner_found pulses in these states are ignored. The core holds its next result.

## Timing
- Reset values:
  - all strobes 0;
  - tx_valid=0, tx_data=0, job_byte=0;
  - rx_err_cnt=0;
  - FSM in IDLE;
  - counters 0.
- Reset mid-frame abandons the frame with no further strobes. A reset during transmit drops tx_valid immediately. Outputs are asynchronous-cleared.
- job_shift and job_byte are combinational from the rx handshake. Zero-cycle latency from byte acceptance to shift.
- Last payload byte accepted in cycle N: miner_start is high in cycle N+1.
- miner_found in cycle N:
  - nonce_load in N+1;
  - header tx_valid in N+2;
  - first nonce_shift in the cycle after the header handshake;
  - data byte valid the following cycle.
- Minimum per-byte transmit period is 2 cycles.
- tx_data and tx_valid must not change while tx_valid=1 && tx_ready=0.
- Timeout counter: RX_TIMEOUT-wide. It resets on each accepted byte and is active only in RECV.

## Structure
- Shared package miner_pkg holds:
  - the header constants HDR_JOB=8'h4A and HDR_NONCE=8'h4E;
  - the JOB_BYTES and NONCE_BYTES defaults;
  - the FSM state encoding.
- A single optional sub-module, io_timeout_cnt, provides a loadable down-counter with an expired flag. Everything else stays flat.

## Test plan
- Send 0x4A plus bytes 0x00..0x4F: expect 80 job_shift strobes with matching job_byte, then miner_start exactly one cycle after the last byte.
- Send garbage 0x11, 0x22 in IDLE, then a valid frame: expect no job_shift for the garbage and a normal start.
- Pulse miner_found with nonce 0x0123456789ABCDEF, tx_ready=1: expect tx bytes 4E 01 23 45 67 89 AB CD EF, then the FSM back in RUN.
- Same result with tx_ready toggling every 3 cycles: tx_data is stable while stalled and the byte sequence is identical.
- Send header plus 10 bytes, then silence for RX_TIMEOUT cycles: expect return to IDLE, rx_err_cnt=1, and no miner_start.
- In RUN, send 0x4A in the same cycle as miner_found: expect the result transmitted and no miner_abort. Then send 0x4A in RUN: expect miner_abort pulse and RECV. Assert rst mid-transmit: expect all outputs at reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: header bytes, payload sizes and
// FSM encoding shared by the host I/O sequencer.
package miner_pkg;

  localparam logic [7:0] HDR_JOB   = 8'h4A;
  localparam logic [7:0] HDR_NONCE = 8'h4E;

  localparam int JOB_BYTES_DFLT   = 80;
  localparam int NONCE_BYTES_DFLT = 8;
  localparam int RX_TIMEOUT_DFLT  = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_START,
    S_RUN,
    S_LOAD,
    S_HDR,
    S_SHIFT,
    S_SEND
  } io_state_e;

endpackage

// File: rtl/miner_io_ctrl_timeout.sv
// io_timeout_cnt: loadable down-counter that
// stops at zero and flags expiry.
module io_timeout_cnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // reload on demand, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/miner_io_ctrl.sv
// miner_io_ctrl: host link sequencer, loads jobs
// into the miner and frames found nonces back.
module miner_io_ctrl
  import miner_pkg::*;
#(
  parameter int JOB_BYTES   = JOB_BYTES_DFLT,
  parameter int NONCE_BYTES = NONCE_BYTES_DFLT,
  parameter int RX_TIMEOUT  = RX_TIMEOUT_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  job_byte,
  output logic        job_shift,
  output logic        miner_start,
  output logic        miner_abort,
  input  logic        miner_found,
  input  logic [63:0] found_nonce,
  output logic        nonce_load,
  output logic        nonce_shift,
  input  logic [7:0]  nonce_byte,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  rx_err_cnt
);

  localparam int CW = $clog2(JOB_BYTES + 1);
  localparam int TW = $clog2(RX_TIMEOUT + 1);

  io_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    err_q;
  logic          start_q;
  logic          abort_q;
  logic          load_q;
  logic          shift_q;
  logic          txv_q;
  logic          rx_fire;
  logic          tx_fire;
  logic          is_hdr;
  logic          to_exp;
  logic          unused_nonce;

  // the nonce shift register loads found_nonce itself
  assign unused_nonce = ^found_nonce;

  assign rx_ready = (state_q == S_IDLE)
                 || (state_q == S_RECV)
                 || (state_q == S_RUN);
  assign rx_fire   = rx_valid && rx_ready;
  assign is_hdr    = (rx_data == HDR_JOB);
  assign tx_fire   = txv_q && tx_ready;
  assign job_shift = rx_fire && (state_q == S_RECV);
  assign job_byte  = job_shift ? rx_data : 8'h00;

  io_timeout_cnt #(
    .W (TW)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rx_fire),
    .load_val_i (TW'(RX_TIMEOUT - 1)),
    .en_i       (state_q == S_RECV),
    .expired_o  (to_exp)
  );

  // tx byte source follows the frame phase
  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      state_q == S_HDR:  tx_data = HDR_NONCE;
      state_q == S_SEND: tx_data = nonce_byte;
      default: ;
    endcase
  end

  // sequencer with registered strobes and tx_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      txv_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_fire && is_hdr) begin
            state_q <= S_RECV;
            cnt_q   <= '0;
          end
        end
        S_RECV: begin
          if (rx_fire) begin
            if (cnt_q == CW'(JOB_BYTES - 1)) begin
              state_q <= S_START;
              start_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (to_exp) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            if (err_q != 8'hFF) begin
              err_q <= err_q + 8'd1;
            end
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (miner_found) begin
            state_q <= S_LOAD;
            load_q  <= 1'b1;
          end else if (rx_fire && is_hdr) begin
            state_q <= S_RECV;
            abort_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_LOAD: begin
          state_q <= S_HDR;
          txv_q   <= 1'b1;
          cnt_q   <= '0;
        end
        S_HDR: begin
          if (tx_fire) begin
            state_q <= S_SHIFT;
            txv_q   <= 1'b0;
            shift_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          state_q <= S_SEND;
          txv_q   <= 1'b1;
        end
        S_SEND: begin
          if (tx_fire) begin
            txv_q <= 1'b0;
            if (cnt_q == CW'(NONCE_BYTES - 1)) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end else begin
              state_q <= S_SHIFT;
              shift_q <= 1'b1;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miner_start = start_q;
  assign miner_abort = abort_q;
  assign nonce_load  = load_q;
  assign nonce_shift = shift_q;
  assign tx_valid    = txv_q;
  assign rx_err_cnt  = err_q;

endmodule

// File: tb/tb_miner_io_ctrl.sv
// tb_miner_io_ctrl: scoreboard bench for the
// miner host I/O sequencer.
module tb_miner_io_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  job_byte;
  logic        job_shift;
  logic        miner_start;
  logic        miner_abort;
  logic        miner_found = 1'b0;
  logic [63:0] found_nonce = 64'h0;
  logic        nonce_load;
  logic        nonce_shift;
  logic [7:0]  nonce_byte;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_err_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int found_cyc = 0;
  int last_shift_cyc = 0;
  int jshift_cnt = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  int tx_cnt = 0;
  int tx_mode = 0;
  int tcnt = 0;
  bit hdr_pend = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [71:0] sr = 72'h0;

  logic [7:0] jobq[$];
  logic [7:0] txq[$];

  miner_io_ctrl #(
    .RX_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .job_byte    (job_byte),
    .job_shift   (job_shift),
    .miner_start (miner_start),
    .miner_abort (miner_abort),
    .miner_found (miner_found),
    .found_nonce (found_nonce),
    .nonce_load  (nonce_load),
    .nonce_shift (nonce_shift),
    .nonce_byte  (nonce_byte),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external nonce shift register model
  always @(posedge clk) begin
    if (nonce_load) sr <= {8'h00, found_nonce};
    else if (nonce_shift) sr <= sr << 8;
  end
  assign nonce_byte = sr[71:64];

  // host tx_ready: steady or toggling every 3 cycles
  always @(posedge clk) begin
    #1;
    if (tx_mode == 0) begin
      tx_ready = 1'b1;
    end else begin
      tcnt++;
      if (tcnt >= 3) begin
        tcnt = 0;
        tx_ready = ~tx_ready;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // output monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      hdr_pend = 1'b0;
    end else begin
      if (job_shift) begin
        jshift_cnt++;
        last_shift_cyc = cyc;
        if (jobq.size() == 0) chk("job_extra", 1, 0);
        else chk("job_byte", job_byte, jobq.pop_front());
      end
      if (miner_start) begin
        start_cnt++;
        chk("start_lat", cyc - last_shift_cyc, 1);
      end
      if (miner_abort) abort_cnt++;
      if (nonce_load) begin
        chk("load_lat", cyc - found_cyc, 1);
        hdr_pend = 1'b1;
      end else if (hdr_pend && tx_valid) begin
        chk("hdr_lat", cyc - found_cyc, 2);
        hdr_pend = 1'b0;
      end
      if (prev_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        if (txq.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", tx_data, txq.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input bit push);
    bit ok;
    ok = 1'b0;
    if (push) jobq.push_back(b);
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rx_wait", 0, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    send_byte(8'h4A, 1'b0);
    for (int i = 0; i < 80; i++) begin
      send_byte(base + 8'(i), 1'b1);
    end
  endtask

  task automatic push_nonce(input logic [63:0] n);
    txq.push_back(8'h4E);
    for (int i = 7; i >= 0; i--) begin
      txq.push_back(n[i*8 +: 8]);
    end
  endtask

  task automatic pulse_found(input logic [63:0] n);
    @(posedge clk);
    #1;
    found_nonce = n;
    miner_found = 1'b1;
    found_cyc = cyc;
    push_nonce(n);
    @(posedge clk);
    #1;
    miner_found = 1'b0;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < 600; i++) begin
      if (txq.size() == 0) break;
      @(posedge clk);
    end
    if (txq.size() != 0) chk("tx_wait", txq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_tx;
    repeat (2) @(negedge clk);
    chk("rst_err", rx_err_cnt, 0);
    chk("rst_tx", {tx_valid, tx_data}, 0);
    chk("rst_job", {job_shift, job_byte}, 0);
    chk("rst_strb",
        {miner_start, miner_abort, nonce_load, nonce_shift}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // garbage in IDLE, then a full job frame
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_frame(8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("job_cnt", jshift_cnt, 80);
    chk("start_cnt", start_cnt, 1);
    chk("jobq_empty", jobq.size(), 0);

    // result with host always ready
    base_tx = tx_cnt;
    pulse_found(64'h0123456789ABCDEF);
    wait_tx_done();
    chk("tx_cnt_a", tx_cnt - base_tx, 9);

    // same result with host stalling
    tx_mode = 1;
    base_tx = tx_cnt;
    pulse_found(64'h0123456789ABCDEF);
    wait_tx_done();
    tx_mode = 0;
    chk("tx_cnt_b", tx_cnt - base_tx, 9);

    // header and found in the same RUN cycle
    @(posedge clk);
    #1;
    rx_data = 8'h4A;
    rx_valid = 1'b1;
    found_nonce = 64'hFEDCBA9876543210;
    miner_found = 1'b1;
    found_cyc = cyc;
    push_nonce(64'hFEDCBA9876543210);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    miner_found = 1'b0;
    wait_tx_done();
    chk("no_abort", abort_cnt, 0);

    // header in RUN aborts and reloads
    send_byte(8'h4A, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_cnt", abort_cnt, 1);

    // partial frame then silence
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b1);
    end
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("err_early", rx_err_cnt, 0);
    @(posedge clk);
    #1;
    chk("err_cnt", rx_err_cnt, 1);
    send_byte(8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("to_nostart", start_cnt, 1);
    chk("jobq_empty2", jobq.size(), 0);

    // reset in the middle of a transmit
    send_frame(8'h80);
    repeat (3) @(posedge clk);
    #1;
    chk("start_cnt2", start_cnt, 2);
    pulse_found(64'h1122334455667788);
    for (int i = 0; i < 200; i++) begin
      if (txq.size() <= 5) break;
      @(posedge clk);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", {tx_valid, tx_data}, 0);
    chk("mid_rst_strb",
        {miner_start, miner_abort, nonce_load, nonce_shift}, 0);
    chk("mid_rst_err", rx_err_cnt, 0);
    chk("mid_rst_rdy", rx_ready, 1);
    txq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_tx", {tx_valid, nonce_load, nonce_shift}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
